tmp75b_temp_monitor: RTL

Post-processing stage downstream of the TMP75B read controller. It accepts each 16-bit raw temperature register word with a one-cycle valid strobe and extracts the signed 12-bit temperature. It maintains a 4-sample moving average, min/max tracking, an over-temperature alarm with hysteresis, and a stale-data watchdog. Its outputs feed the status/VIO and fan-control logic.

---
 rtl/tmp75b_mon_if.sv | 24 ++
 rtl/tmp75b_temp_monitor.sv | 103 ++++++++++
 2 files changed

// File: rtl/tmp75b_mon_if.sv
// Sample/result bundle between the TMP75B read controller, this monitor and
// the status/fan-control consumers.
interface tmp75b_mon_if;
  logic        [15:0] raw_temp;
  logic               raw_valid;
  logic               clr_minmax;
  logic signed [11:0] temp_cur;
  logic signed [11:0] temp_avg;
  logic signed [11:0] temp_min;
  logic signed [11:0] temp_max;
  logic               out_valid;
  logic               alarm;
  logic               stale;

  modport master (
    output raw_temp, raw_valid, clr_minmax,
    input  temp_cur, temp_avg, temp_min, temp_max, out_valid, alarm, stale
  );

  modport slave (
    input  raw_temp, raw_valid, clr_minmax,
    output temp_cur, temp_avg, temp_min, temp_max, out_valid, alarm, stale
  );
endinterface

// File: rtl/tmp75b_temp_monitor.sv
// TMP75B temperature post-processing: average, min/max, hysteresis alarm and
// stale watchdog. Define TMP75B_MON_AVG_EN to enable the 4-sample moving average.
//
// state | meaning
// EMPTY | no sample since reset, window unloaded
// RUN   | window holds the last 4 samples
module tmp75b_temp_monitor #(
  parameter logic signed [11:0] T_HIGH         = 12'sd1280,
  parameter logic signed [11:0] T_LOW          = 12'sd1200,
  parameter logic        [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
  input  logic         clk,
  input  logic         rst,
  tmp75b_mon_if.slave  bus
);

  logic signed [11:0] s;
  logic signed [11:0] avg_next;
  logic               s1_valid;
  logic               s1_init;
  logic               init_pend;
  logic        [31:0] wd_cnt;
  logic               unused_lsbs;

  assign s           = bus.raw_temp[15:4];
  assign unused_lsbs = ^bus.raw_temp[3:0];
  assign bus.stale   = (wd_cnt == TIMEOUT_CYCLES);

`ifdef TMP75B_MON_AVG_EN
  typedef enum logic {EMPTY, RUN} win_state_t;
  win_state_t         state;
  logic signed [11:0] win [4];
  logic signed [13:0] sum;

  // sum[13:2] is sum >>> 2 truncated; the quotient always fits 12 bits.
  assign avg_next = sum[13:2];
`else
  assign avg_next = bus.temp_cur;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.temp_cur  <= '0;
      bus.temp_avg  <= '0;
      bus.temp_min  <= '0;
      bus.temp_max  <= '0;
      bus.out_valid <= 1'b0;
      bus.alarm     <= 1'b0;
      s1_valid      <= 1'b0;
      s1_init       <= 1'b0;
      init_pend     <= 1'b1;
      wd_cnt        <= '0;
`ifdef TMP75B_MON_AVG_EN
      state <= EMPTY;
      sum   <= '0;
      for (int i = 0; i < 4; i++) win[i] <= '0;
`endif
    end else begin
      s1_valid      <= bus.raw_valid;
      bus.out_valid <= s1_valid;

      if (bus.raw_valid) begin
        bus.temp_cur <= s;
        s1_init      <= init_pend | bus.clr_minmax;
        init_pend    <= 1'b0;
`ifdef TMP75B_MON_AVG_EN
        case (state)
          EMPTY: begin
            for (int i = 0; i < 4; i++) win[i] <= s;
            sum   <= {s, 2'b00};
            state <= RUN;
          end
          default: begin
            win[0] <= s;
            for (int i = 1; i < 4; i++) win[i] <= win[i-1];
            sum   <= sum + {{2{s[11]}}, s} - {{2{win[3][11]}}, win[3]};
            state <= RUN;
          end
        endcase
`endif
      end else if (bus.clr_minmax) begin
        init_pend <= 1'b1;
      end

      if (s1_valid) begin
        bus.temp_avg <= avg_next;
        if (s1_init) begin
          bus.temp_min <= bus.temp_cur;
          bus.temp_max <= bus.temp_cur;
        end else begin
          if (bus.temp_cur < bus.temp_min) bus.temp_min <= bus.temp_cur;
          if (bus.temp_cur > bus.temp_max) bus.temp_max <= bus.temp_cur;
        end
        if (avg_next >= T_HIGH)     bus.alarm <= 1'b1;
        else if (avg_next <= T_LOW) bus.alarm <= 1'b0;
      end

      if (bus.raw_valid)                wd_cnt <= '0;
      else if (wd_cnt != TIMEOUT_CYCLES) wd_cnt <= wd_cnt + 32'd1;
    end
  end

endmodule
